// File: rtl/wb_pkg.sv
// Shared writeback-stage types: result source select, skid FSM states and load funct3 codes.
package wb_pkg;

    typedef enum logic [1:0] {
        RS_ALU  = 2'b00,
        RS_LOAD = 2'b01,
        RS_PC4  = 2'b10,
        RS_ZERO = 2'b11
    } result_src_e;

    // State encodes how many resolved results the stage currently holds.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } wb_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/wb_stage_pipe_if.sv
// Writeback-stage bus: MEM/WB result handshake in, register-file write port out.
// wb_instret is present only when WB_INSTRET_EN is defined.
interface wb_stage_pipe_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    localparam int OFF_W = $clog2(XLEN / 8);

    logic              in_valid;
    logic              in_ready;
    logic              in_regwrite;
    logic [1:0]        in_result_src;
    logic [XLEN-1:0]   in_alu_result;
    logic [XLEN-1:0]   in_readdata;
    logic [XLEN-1:0]   in_pc_plus_4;
    logic [REG_AW-1:0] in_rd;
    logic [2:0]        in_funct3;
    logic [OFF_W-1:0]  in_byte_off;
    logic              rf_ready;
    logic              wb_valid;
    logic              wb_regwrite;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_result;
`ifdef WB_INSTRET_EN
    logic [63:0]       wb_instret;

    modport slave (
        input  in_valid, in_regwrite, in_result_src, in_alu_result, in_readdata,
               in_pc_plus_4, in_rd, in_funct3, in_byte_off, rf_ready,
        output in_ready, wb_valid, wb_regwrite, wb_rd, wb_result, wb_instret
    );
    modport master (
        output in_valid, in_regwrite, in_result_src, in_alu_result, in_readdata,
               in_pc_plus_4, in_rd, in_funct3, in_byte_off, rf_ready,
        input  in_ready, wb_valid, wb_regwrite, wb_rd, wb_result, wb_instret
    );
`else
    modport slave (
        input  in_valid, in_regwrite, in_result_src, in_alu_result, in_readdata,
               in_pc_plus_4, in_rd, in_funct3, in_byte_off, rf_ready,
        output in_ready, wb_valid, wb_regwrite, wb_rd, wb_result
    );
    modport master (
        output in_valid, in_regwrite, in_result_src, in_alu_result, in_readdata,
               in_pc_plus_4, in_rd, in_funct3, in_byte_off, rf_ready,
        input  in_ready, wb_valid, wb_regwrite, wb_rd, wb_result
    );
`endif

endinterface

// File: rtl/wb_load_align.sv
// Combinational load-data extract and extend: shifts the requested byte lane down
// and sign/zero-extends according to funct3. Unsupported funct3 passes the word through.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int  XLEN  = 32,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  i_data,
    input  logic [2:0]       i_funct3,
    input  logic [OFF_W-1:0] i_byte_off,
    output logic [XLEN-1:0]  o_data
);

    localparam bit IS64 = (XLEN == 64);

    logic [OFF_W-1:0] w_off;
    logic [31:0]      w_low;

    always_comb begin
        // Offset low bits below the access size are dropped, never trapped.
        w_off = '0;
        case (i_funct3)
            F3_LB, F3_LBU: w_off = i_byte_off;
            F3_LH, F3_LHU: w_off = i_byte_off & ~OFF_W'(1);
            F3_LW, F3_LWU: w_off = i_byte_off & ~OFF_W'(3);
            default:       w_off = '0;
        endcase
        w_low = 32'(i_data >> {w_off, 3'b000});

        o_data = i_data;
        case (i_funct3)
            F3_LB:   o_data = XLEN'($signed(w_low[7:0]));
            F3_LBU:  o_data = XLEN'(w_low[7:0]);
            F3_LH:   o_data = XLEN'($signed(w_low[15:0]));
            F3_LHU:  o_data = XLEN'(w_low[15:0]);
            F3_LW:   o_data = XLEN'($signed(w_low));
            F3_LWU:  if (IS64) o_data = XLEN'(w_low);
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// Writeback stage with 2-entry skid buffer between MEM/WB and the register-file port.
// Optional macro WB_INSTRET_EN adds a 64-bit retired-instruction counter on wb_instret.
module wb_stage_pipe
    import wb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input logic          clk,
    input logic          reset,
    wb_stage_pipe_if.slave bus
);

    typedef struct packed {
        logic              regwrite;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   result;
    } wb_entry_t;

    wb_state_e       r_state, w_next;
    wb_entry_t       r_out, r_skid, w_new;
    logic            r_in_ready;
    logic            w_accept, w_pop;
    logic            w_load_out, w_load_skid, w_skid_to_out;
    logic [XLEN-1:0] w_load_data;

    wb_load_align #(.XLEN(XLEN)) u_align (
        .i_data     (bus.in_readdata),
        .i_funct3   (bus.in_funct3),
        .i_byte_off (bus.in_byte_off),
        .o_data     (w_load_data)
    );

    // Results are resolved before storage so the skid slot holds final values.
    always_comb begin
        w_new          = '0;
        w_new.regwrite = bus.in_regwrite & (bus.in_rd != '0);
        w_new.rd       = bus.in_rd;
        case (result_src_e'(bus.in_result_src))
            RS_ALU:  w_new.result = bus.in_alu_result;
            RS_LOAD: w_new.result = w_load_data;
            RS_PC4:  w_new.result = bus.in_pc_plus_4;
            default: w_new.result = '0;
        endcase
    end

    assign w_accept = bus.in_valid & r_in_ready;
    assign w_pop    = (r_state != ST_EMPTY) & bus.rf_ready;

    always_comb begin
        w_next        = r_state;
        w_load_out    = 1'b0;
        w_load_skid   = 1'b0;
        w_skid_to_out = 1'b0;
        case (r_state)
            ST_EMPTY: if (w_accept) begin
                w_next     = ST_ONE;
                w_load_out = 1'b1;
            end
            ST_ONE: begin
                if (w_accept && w_pop) begin
                    w_load_out = 1'b1;
                end else if (w_accept) begin
                    w_next      = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (w_pop) begin
                    w_next = ST_EMPTY;
                end
            end
            ST_TWO: if (w_pop) begin
                w_next        = ST_ONE;
                w_skid_to_out = 1'b1;
            end
            default: w_next = ST_EMPTY;
        endcase
    end

    // in_ready comes from a flop so rf_ready never reaches it combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != ST_TWO);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out  <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_out)         r_out <= w_new;
            else if (w_skid_to_out) r_out <= r_skid;
            if (w_load_skid)        r_skid <= w_new;
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.wb_valid    = (r_state != ST_EMPTY);
    assign bus.wb_regwrite = r_out.regwrite & (r_state != ST_EMPTY);
    assign bus.wb_rd       = r_out.rd;
    assign bus.wb_result   = r_out.result;

`ifdef WB_INSTRET_EN
    logic [63:0] r_instret;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      r_instret <= '0;
        else if (w_pop) r_instret <= r_instret + 64'd1;
    end

    assign bus.wb_instret = r_instret;
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed scoreboard bench for wb_stage_pipe (XLEN=32 main instance, XLEN=64 instance for wide loads).
module tb_wb_stage_pipe;
    import wb_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wb_stage_pipe_if #(.XLEN(32), .REG_AW(5)) bus ();
    wb_stage_pipe_if #(.XLEN(64), .REG_AW(5)) bus64 ();

    wb_stage_pipe #(.XLEN(32), .REG_AW(5)) dut (.clk(clk), .reset(reset), .bus(bus));
    wb_stage_pipe #(.XLEN(64), .REG_AW(5)) dut64 (.clk(clk), .reset(reset), .bus(bus64));

    typedef struct packed {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] res;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur_exp;
    int          n_assert = 0;
    int          n_fail   = 0;
    longint      n_pops   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: record accepts and pops that the coming posedge will perform.
    task automatic tick();
        exp_t e;
        if (bus.in_valid && bus.in_ready) sb.push_back(cur_exp);
        if (bus.wb_valid && bus.rf_ready) begin
            if (sb.size() == 0) begin
                check("pop_unexpected", 64'(bus.wb_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check("pop_result", 64'(bus.wb_result), 64'(e.res));
                check("pop_rd", 64'(bus.wb_rd), 64'(e.rd));
                check("pop_regwrite", 64'(bus.wb_regwrite), 64'(e.rw));
                n_pops++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic rw, input logic [4:0] rd, input logic [1:0] src,
                        input logic [31:0] val, input logic [2:0] f3, input logic [1:0] off,
                        input logic exp_rw, input logic [31:0] exp_res);
        int guard;
        bus.in_regwrite   = rw;
        bus.in_rd         = rd;
        bus.in_result_src = src;
        bus.in_alu_result = (src == RS_ALU)  ? val : 32'hA5A5_A5A5;
        bus.in_readdata   = (src == RS_LOAD) ? val : 32'h5A5A_5A5A;
        bus.in_pc_plus_4  = (src == RS_PC4)  ? val : 32'h0F0F_0F0F;
        bus.in_funct3     = f3;
        bus.in_byte_off   = off;
        cur_exp           = '{rw: exp_rw, rd: rd, res: exp_res};
        bus.in_valid      = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) check("send_timeout", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic load64(input logic [63:0] data, input logic [2:0] f3, input logic [2:0] off,
                          input logic [63:0] exp_res, input string tag);
        bus64.in_regwrite   = 1'b1;
        bus64.in_rd         = 5'd3;
        bus64.in_result_src = RS_LOAD;
        bus64.in_readdata   = data;
        bus64.in_funct3     = f3;
        bus64.in_byte_off   = off;
        bus64.in_valid      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus64.in_valid = 1'b0;
        check({tag, "_valid"}, 64'(bus64.wb_valid), 64'd1);
        check(tag, bus64.wb_result, exp_res);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 0; bus.in_regwrite = 0; bus.in_result_src = 0; bus.in_alu_result = 0;
        bus.in_readdata = 0; bus.in_pc_plus_4 = 0; bus.in_rd = 0; bus.in_funct3 = 0;
        bus.in_byte_off = 0; bus.rf_ready = 1;
        bus64.in_valid = 0; bus64.in_regwrite = 0; bus64.in_result_src = 0; bus64.in_alu_result = 0;
        bus64.in_readdata = 0; bus64.in_pc_plus_4 = 0; bus64.in_rd = 0; bus64.in_funct3 = 0;
        bus64.in_byte_off = 0; bus64.rf_ready = 1;

        #1 reset = 1'b1;
        #1;
        check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        check("rst_wb_regwrite", 64'(bus.wb_regwrite), 64'd0);
        check("rst_wb_rd", 64'(bus.wb_rd), 64'd0);
        check("rst_wb_result", 64'(bus.wb_result), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef WB_INSTRET_EN
        check("rst_instret", bus.wb_instret, 64'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // ALU result, one-cycle latency
        send(1'b1, 5'd5, RS_ALU, 32'h1234_5678, 3'b000, 2'd0, 1'b1, 32'h1234_5678);
        check("lat_wb_valid", 64'(bus.wb_valid), 64'd1);
        check("lat_wb_result", 64'(bus.wb_result), 64'h1234_5678);
        drain();

        // Load alignment, back-to-back with continuous pops
        send(1'b1, 5'd6, RS_LOAD, 32'h80FF_7F01, F3_LB,  2'd3, 1'b1, 32'hFFFF_FF80);
        send(1'b1, 5'd7, RS_LOAD, 32'h80FF_7F01, F3_LBU, 2'd3, 1'b1, 32'h0000_0080);
        send(1'b1, 5'd8, RS_LOAD, 32'h80FF_7F01, F3_LH,  2'd2, 1'b1, 32'hFFFF_80FF);
        send(1'b1, 5'd9, RS_LOAD, 32'h80FF_7F01, F3_LH,  2'd3, 1'b1, 32'hFFFF_80FF);
        send(1'b1, 5'd10, RS_LOAD, 32'h80FF_7F01, F3_LHU, 2'd0, 1'b1, 32'h0000_7F01);
        send(1'b1, 5'd11, RS_LOAD, 32'h80FF_7F01, F3_LB,  2'd1, 1'b1, 32'h0000_007F);
        send(1'b1, 5'd12, RS_LOAD, 32'h80FF_7F01, F3_LW,  2'd2, 1'b1, 32'h80FF_7F01);
        send(1'b1, 5'd13, RS_LOAD, 32'h80FF_7F01, 3'b111, 2'd1, 1'b1, 32'h80FF_7F01);
        send(1'b1, 5'd14, RS_LOAD, 32'h80FF_7F01, F3_LWU, 2'd1, 1'b1, 32'h80FF_7F01);
        send(1'b1, 5'd15, RS_ZERO, 32'hFFFF_FFFF, 3'b000, 2'd0, 1'b1, 32'h0000_0000);
        send(1'b0, 5'd16, RS_ALU, 32'h0000_0042, 3'b000, 2'd0, 1'b0, 32'h0000_0042);
        drain();

        // x0 write suppression
        send(1'b1, 5'd0, RS_PC4, 32'h0000_0104, 3'b000, 2'd0, 1'b0, 32'h0000_0104);
        check("x0_wb_valid", 64'(bus.wb_valid), 64'd1);
        check("x0_wb_regwrite", 64'(bus.wb_regwrite), 64'd0);
        drain();

        // Backpressure: fill both entries, hold output, refuse a third
        bus.rf_ready = 1'b0;
        send(1'b1, 5'd1, RS_ALU, 32'hAAAA_0001, 3'b000, 2'd0, 1'b1, 32'hAAAA_0001);
        send(1'b1, 5'd2, RS_ALU, 32'hBBBB_0002, 3'b000, 2'd0, 1'b1, 32'hBBBB_0002);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        check("full_hold_result", 64'(bus.wb_result), 64'hAAAA_0001);
        bus.in_alu_result = 32'hCCCC_0003;
        bus.in_valid      = 1'b1;
        tick();
        tick();
        bus.in_valid = 1'b0;
        check("stall_hold_valid", 64'(bus.wb_valid), 64'd1);
        check("stall_hold_result", 64'(bus.wb_result), 64'hAAAA_0001);
        check("stall_hold_rd", 64'(bus.wb_rd), 64'd1);
        bus.rf_ready = 1'b1;
        tick();
        check("skid_out_result", 64'(bus.wb_result), 64'hBBBB_0002);
        check("skid_in_ready", 64'(bus.in_ready), 64'd1);
        drain();
        check("drained_in_ready", 64'(bus.in_ready), 64'd1);

        // Reset while both entries are occupied
        bus.rf_ready = 1'b0;
        send(1'b1, 5'd20, RS_ALU, 32'hDEAD_0001, 3'b000, 2'd0, 1'b1, 32'hDEAD_0001);
        send(1'b1, 5'd21, RS_ALU, 32'hDEAD_0002, 3'b000, 2'd0, 1'b1, 32'hDEAD_0002);
        check("pre_rst_in_ready", 64'(bus.in_ready), 64'd0);
        #2 reset = 1'b1;
        #1;
        check("midrst_wb_valid", 64'(bus.wb_valid), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        sb.delete();
        n_pops = 0;
        @(negedge clk);
        reset = 1'b0;
        bus.rf_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("postrst_wb_valid", 64'(bus.wb_valid), 64'd0);

        // Ten retirements including rd=0
        for (int i = 0; i < 10; i++) begin
            send(1'b1, 5'(i), RS_ALU, 32'h100 + 32'(i), 3'b000, 2'd0, (i != 0), 32'h100 + 32'(i));
        end
        drain();
        check("pops_after_reset", 64'(n_pops), 64'd10);
`ifdef WB_INSTRET_EN
        check("instret", bus.wb_instret, 64'd10);
`endif

        // XLEN=64 instance
        load64(64'hFFFF_FFFF_0000_0000, F3_LWU, 3'd4, 64'h0000_0000_FFFF_FFFF, "x64_lwu");
        load64(64'hFFFF_FFFF_0000_0000, F3_LW,  3'd4, 64'hFFFF_FFFF_FFFF_FFFF, "x64_lw");
        load64(64'h0123_4567_89AB_CDEF, F3_LD,  3'd5, 64'h0123_4567_89AB_CDEF, "x64_ld");
        load64(64'h8000_0000_0000_0000, F3_LB,  3'd7, 64'hFFFF_FFFF_FFFF_FF80, "x64_lb");
        load64(64'h8000_0000_0000_0000, F3_LH,  3'd7, 64'hFFFF_FFFF_FFFF_8000, "x64_lh");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
